// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall/flush generation, branch/exception PC redirect, exception drain FSM.
// Optional macro PIPE_CTRL_EXC_CNT_EN adds a saturating exception-entry counter (exc_cnt / exc_cnt_clr).
module pipe_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0100,
    parameter int                EXC_DRAIN  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              ex_en,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_addr,
    input  logic              mem_en,
    input  logic              mem_miss_align,
    input  logic [ADDR_W-1:0] mem_pc,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              pc_load,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_busy
`ifdef PIPE_CTRL_EXC_CNT_EN
    ,
    input  logic              exc_cnt_clr,
    output logic [15:0]       exc_cnt
`endif
);

    localparam logic [3:0] DRAIN_INIT = 4'(EXC_DRAIN);

    // Drain counter is 4 bits wide, so only 1..15 is meaningful.
    if (EXC_DRAIN < 1 || EXC_DRAIN > 15) begin : g_bad_drain
        $error("pipe_ctrl: EXC_DRAIN must be in 1..15");
    end

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] epc_q, epc_d;

    logic busy;
    logic exc_req;
    logic br_req;

    assign busy    = if_busy | mem_busy;
    assign exc_req = mem_en & mem_miss_align;
    assign br_req  = ex_en & ex_br_taken;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                // A busy bus defers any pending exception until it drops.
                if (!busy && exc_req) begin
                    state_d = ST_EXC;
                    cnt_d   = DRAIN_INIT;
                    epc_d   = mem_pc;
                end
            end
            ST_EXC: begin
                if (!busy) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        pc_load   = 1'b0;
        new_pc    = '0;
        case (state_q)
            ST_RUN: begin
                if (busy) begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    mem_stall = 1'b1;
                end else if (exc_req) begin
                    if_flush  = 1'b1;
                    id_flush  = 1'b1;
                    ex_flush  = 1'b1;
                    mem_flush = 1'b1;
                    pc_load   = 1'b1;
                    new_pc    = EXC_VECTOR;
                end else if (br_req) begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    pc_load  = 1'b1;
                    new_pc   = ex_br_addr;
                end else if (ld_hazard) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end
            end
            ST_EXC: begin
                // Stall takes precedence over the drain flushes while the bus is busy.
                if (busy) begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    mem_stall = 1'b1;
                end else begin
                    if_flush  = 1'b1;
                    id_flush  = 1'b1;
                    ex_flush  = 1'b1;
                    mem_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign epc      = epc_q;
    assign exc_busy = (state_q == ST_EXC);

`ifdef PIPE_CTRL_EXC_CNT_EN
    logic        exc_entry;
    logic [15:0] exc_cnt_q;

    assign exc_entry = (state_q == ST_RUN) && (state_d == ST_EXC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_cnt_q <= 16'd0;
        end else if (exc_cnt_clr) begin
            exc_cnt_q <= 16'd0;
        end else if (exc_entry && exc_cnt_q != 16'hFFFF) begin
            exc_cnt_q <= exc_cnt_q + 16'd1;
        end
    end

    assign exc_cnt = exc_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: inputs change on the falling edge, outputs are checked 1ns later.
// Build with PIPE_CTRL_EXC_CNT_EN defined to also exercise the exception counter.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard;
    logic        ex_en, ex_br_taken, mem_en, mem_miss_align;
    logic [31:0] ex_br_addr, mem_pc;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        pc_load, exc_busy;
    logic [31:0] new_pc, epc;
`ifdef PIPE_CTRL_EXC_CNT_EN
    logic        exc_cnt_clr;
    logic [15:0] exc_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_busy        (if_busy),
        .mem_busy       (mem_busy),
        .ld_hazard      (ld_hazard),
        .ex_en          (ex_en),
        .ex_br_taken    (ex_br_taken),
        .ex_br_addr     (ex_br_addr),
        .mem_en         (mem_en),
        .mem_miss_align (mem_miss_align),
        .mem_pc         (mem_pc),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .ex_stall       (ex_stall),
        .mem_stall      (mem_stall),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .ex_flush       (ex_flush),
        .mem_flush      (mem_flush),
        .pc_load        (pc_load),
        .new_pc         (new_pc),
        .epc            (epc),
        .exc_busy       (exc_busy)
`ifdef PIPE_CTRL_EXC_CNT_EN
        ,
        .exc_cnt_clr    (exc_cnt_clr),
        .exc_cnt        (exc_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stall/flush vector order: {if,id,ex,mem stall, if,id,ex,mem flush}
    localparam logic [7:0] SF_NONE  = 8'b0000_0000;
    localparam logic [7:0] SF_STALL = 8'b1111_0000;
    localparam logic [7:0] SF_FLUSH = 8'b0000_1111;
    localparam logic [7:0] SF_BR    = 8'b0000_1100;
    localparam logic [7:0] SF_HAZ   = 8'b1100_0010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] sf, input logic pcl,
                           input logic [31:0] npc, input logic eb);
        chk({tag, "/stall_flush"},
            {24'd0, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush},
            {24'd0, sf});
        chk({tag, "/pc_load"}, {31'd0, pc_load}, {31'd0, pcl});
        chk({tag, "/new_pc"}, new_pc, npc);
        chk({tag, "/exc_busy"}, {31'd0, exc_busy}, {31'd0, eb});
    endtask

    // Driver tasks
    task automatic clear_inputs();
        if_busy = 0; mem_busy = 0; ld_hazard = 0;
        ex_en = 0; ex_br_taken = 0; ex_br_addr = '0;
        mem_en = 0; mem_miss_align = 0; mem_pc = '0;
`ifdef PIPE_CTRL_EXC_CNT_EN
        exc_cnt_clr = 0;
`endif
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic raise_exc(input logic [31:0] pc);
        mem_en = 1; mem_miss_align = 1; mem_pc = pc;
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_out("in_reset", SF_NONE, 0, 32'h0, 0);
        chk("in_reset/epc", epc, 32'h0);

        @(negedge clk);
        reset = 1;
        #1;
        chk_out("after_reset", SF_NONE, 0, 32'h0, 0);
        chk("after_reset/epc", epc, 32'h0);

        // Taken branch
        @(negedge clk);
        ex_en = 1; ex_br_taken = 1; ex_br_addr = 32'h0000_0040;
        #1;
        chk_out("branch", SF_BR, 1, 32'h40, 0);

        // Branch resolved but EX invalid: no redirect
        @(negedge clk);
        ex_en = 0;
        #1;
        chk_out("branch_no_ex_en", SF_NONE, 0, 32'h0, 0);

        // Load-use hazard for one cycle
        @(negedge clk);
        clear_inputs();
        ld_hazard = 1;
        #1;
        chk_out("ld_hazard", SF_HAZ, 0, 32'h0, 0);
        @(negedge clk);
        ld_hazard = 0;
        #1;
        chk_out("ld_hazard_gone", SF_NONE, 0, 32'h0, 0);

        // Busy beats branch and hazard
        @(negedge clk);
        if_busy = 1; ld_hazard = 1; ex_en = 1; ex_br_taken = 1; ex_br_addr = 32'h80;
        #1;
        chk_out("if_busy", SF_STALL, 0, 32'h0, 0);

        // Exception and branch in the same cycle: exception wins
        @(negedge clk);
        clear_inputs();
        raise_exc(32'h0000_1234);
        ex_en = 1; ex_br_taken = 1; ex_br_addr = 32'h40;
        #1;
        chk_out("exc_entry", SF_FLUSH, 1, 32'h100, 0);

        // Drain cycle 1: branch/hazard/new exception are ignored
        @(negedge clk);
        clear_inputs();
        ex_en = 1; ex_br_taken = 1; ex_br_addr = 32'h44; ld_hazard = 1;
        raise_exc(32'h0000_5555);
        #1;
        chk_out("exc_drain1", SF_FLUSH, 0, 32'h0, 1);
        chk("exc_drain1/epc", epc, 32'h0000_1234);

        next_cycle();
        chk_out("exc_drain2", SF_FLUSH, 0, 32'h0, 1);
        chk("exc_drain2/epc", epc, 32'h0000_1234);

        @(negedge clk);
        clear_inputs();
        #1;
        chk_out("exc_done", SF_NONE, 0, 32'h0, 0);

        // Exception, then mem_busy for 3 drain cycles: 3+2 cycles in EXC
        @(negedge clk);
        raise_exc(32'h0000_2000);
        #1;
        chk_out("exc2_entry", SF_FLUSH, 1, 32'h100, 0);
        @(negedge clk);
        clear_inputs();
        mem_busy = 1;
        #1;
        chk_out("exc2_busy1", SF_STALL, 0, 32'h0, 1);
        chk("exc2/epc", epc, 32'h0000_2000);
        next_cycle();
        chk_out("exc2_busy2", SF_STALL, 0, 32'h0, 1);
        next_cycle();
        chk_out("exc2_busy3", SF_STALL, 0, 32'h0, 1);
        @(negedge clk);
        mem_busy = 0;
        #1;
        chk_out("exc2_drain1", SF_FLUSH, 0, 32'h0, 1);
        next_cycle();
        chk_out("exc2_drain2", SF_FLUSH, 0, 32'h0, 1);
        next_cycle();
        chk_out("exc2_done", SF_NONE, 0, 32'h0, 0);

        // Busy with pending exception: deferred until busy drops
        @(negedge clk);
        mem_busy = 1;
        raise_exc(32'h0000_3000);
        #1;
        chk_out("busy_exc", SF_STALL, 0, 32'h0, 0);
        next_cycle();
        chk_out("busy_exc_held", SF_STALL, 0, 32'h0, 0);
        chk("busy_exc_held/epc", epc, 32'h0000_2000);
        @(negedge clk);
        mem_busy = 0;
        #1;
        chk_out("busy_exc_taken", SF_FLUSH, 1, 32'h100, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk_out("exc3_drain1", SF_FLUSH, 0, 32'h0, 1);
        chk("exc3/epc", epc, 32'h0000_3000);

        // Asynchronous reset mid-EXC
        #2;
        reset = 0;
        #1;
        chk("reset_mid_exc/exc_busy", {31'd0, exc_busy}, 32'd0);
        chk("reset_mid_exc/epc", epc, 32'h0);
        @(negedge clk);
        reset = 1;
        #1;
        chk_out("after_reset2", SF_NONE, 0, 32'h0, 0);

`ifdef PIPE_CTRL_EXC_CNT_EN
        chk("cnt/after_reset", {16'd0, exc_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            raise_exc(32'h0000_4000 + 32'(i));
            @(negedge clk);
            clear_inputs();
            repeat (2) @(negedge clk);
        end
        #1;
        chk("cnt/three", {16'd0, exc_cnt}, 32'd3);
        @(negedge clk);
        raise_exc(32'h0000_5000);
        exc_cnt_clr = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("cnt/clear_wins", {16'd0, exc_cnt}, 32'd0);
        chk("cnt/entry_still_taken", {31'd0, exc_busy}, 32'd1);
        repeat (2) @(negedge clk);
        raise_exc(32'h0000_6000);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("cnt/after_clear", {16'd0, exc_cnt}, 32'd1);
        repeat (2) @(negedge clk);
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage core. It generates stall and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and sequences recovery from memory-stage exceptions. Exceptions are currently miss-aligned accesses. It resolves bus-busy stalls, load-use hazards, taken branches and exceptions in a fixed priority order. It drives the PC load path with a redirect address.

Parameters:
ADDR_W, 32, width of PC / address values
EXC_VECTOR, 32'h0000_0100, PC loaded on exception entry
EXC_DRAIN, 2, cycles the pipeline stays flushed after exception entry (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_busy  in  1  instruction bus not ready this cycle
mem_busy  in  1  data bus not ready this cycle
ld_hazard  in  1  ID instruction uses result of load in EX
ex_en  in  1  EX stage holds valid instruction
ex_br_taken  in  1  branch resolved taken in EX
ex_br_addr  in  ADDR_W  branch target
mem_en  in  1  MEM stage holds valid instruction
mem_miss_align  in  1  MEM access miss-aligned
mem_pc  in  ADDR_W  PC of MEM-stage instruction
if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold corresponding pipeline register
if_flush, id_flush, ex_flush, mem_flush  out  1 each  bubble corresponding pipeline register
pc_load  out  1  load new_pc into PC this cycle
new_pc  out  ADDR_W  redirect address
epc  out  ADDR_W  PC of last excepting instruction (registered)
exc_busy  out  1  FSM in EXC state

Behaviour:
- busy = if_busy | mem_busy. Stall/flush/pc_load/new_pc are combinational from state and inputs. epc, state and drain counter are registered.
- Reset (reset low, asynchronous): state=RUN, cnt=0, epc=0. Combinational outputs then evaluate as RUN with the current inputs.
- State RUN, first match wins:
  1. busy: all four stalls=1; no flush; pc_load=0; no state change.
  2. mem_en & mem_miss_align: all four flushes=1; pc_load=1; new_pc=EXC_VECTOR. Next edge: epc<=mem_pc, cnt<=EXC_DRAIN, state<=EXC.
  3. ex_en & ex_br_taken: if_flush=id_flush=1; pc_load=1; new_pc=ex_br_addr.
  4. ld_hazard: if_stall=id_stall=1; ex_flush=1 (bubble). PC holds via if_stall.
  5. Otherwise all outputs 0.
- State EXC:
  - if_flush=id_flush=ex_flush=mem_flush=1.
  - Branch, hazard and new exceptions are ignored. pc_load=0.
  - If busy: all stalls=1 and cnt holds. Otherwise cnt decrements.
  - On the edge where cnt==1 and not busy: state<=RUN.
  - exc_busy=1 throughout.
- Stall and flush for the same stage are never both 1. Stall wins only in busy cases, where no flush is asserted.
- When new_pc is not loading it drives 0.
- Simultaneous miss-align and taken branch: the exception wins and the branch is discarded.
- Simultaneous busy and exception: no action until busy drops. The exception is then taken on the first non-busy cycle if still present.
- Reset asserted mid-EXC: immediate return to RUN, cnt=0, epc=0.
- An EXC_DRAIN value outside 1..15 is a configuration error. Compile a simulation-only check.

Optional Feature:
PIPE_CTRL_EXC_CNT_EN:
- Defined: adds input exc_cnt_clr (1 bit) and output exc_cnt (16 bits).
  - The counter increments on each exception entry, i.e. the RUN->EXC edge, and saturates at 16'hFFFF.
  - exc_cnt_clr clears it synchronously. Clear wins over a same-cycle increment.
  - Reset value is 0.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset low for 2 cycles, then release with all inputs 0 -> all stalls/flushes 0, pc_load=0, epc=0, exc_busy=0.
- ex_en=1, ex_br_taken=1, ex_br_addr=32'h0000_0040 -> same cycle if_flush=id_flush=1, pc_load=1, new_pc=32'h40; ex_flush=mem_flush=0.
- ld_hazard=1 for 1 cycle -> if_stall=id_stall=1, ex_flush=1, mem_stall=0; next cycle all 0.
- mem_en=1, mem_miss_align=1, mem_pc=32'h0000_1234, same cycle ex_br_taken=1 -> new_pc=32'h100 (not branch target); next cycle epc=32'h1234, exc_busy=1.
  - Flushes stay asserted for 2 cycles, then exc_busy=0.
- In EXC with cnt=2, mem_busy=1 for 3 cycles -> all stalls=1, exc_busy stays 1 for 3+2 cycles total, then RUN.
- With PIPE_CTRL_EXC_CNT_EN: three exceptions -> exc_cnt=3; exc_cnt_clr asserted on the cycle of a fourth entry -> exc_cnt=0.
